fifo_uart_framer: RTL and testbench

//  Drains received-byte FIFO into UART transmitter as fixed-length framed packets.

---
 rtl/fifo_uart_framer.sv | 153 +++++++++++++++
 tb/tb_fifo_uart_framer.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_framer.sv
// Drains a byte FIFO into a UART as HDR + PKT_LEN payload + checksum frames.
// Padding bytes keep the host from stalling on a partial frame.
module fifo_uart_framer #(
    parameter int unsigned PKT_LEN = 8,
    parameter logic [7:0]  HDR     = 8'hA0,
    parameter logic [7:0]  PAD     = 8'h00,
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       fifo_empty,
    output logic       fifo_rd,
    input  logic [7:0] fifo_dat,
    output logic [7:0] tx_data,
    output logic       tx_wr,
    input  logic       tx_busy,
    output logic       frame_busy,
    output logic       frame_done,
    output logic [7:0] pad_cnt
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [7:0] LEN = 8'(PKT_LEN);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        TX_ISSUE,
        TX_GUARD,
        TX_WAIT,
        PAYLOAD,
        FETCH,
        DONE
    } state_t;

    state_t        state_q, state_d;
    state_t        ret_q, ret_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [7:0]    sum_q, sum_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_wr_q, tx_wr_d;
    logic          frame_busy_q, frame_busy_d;
    logic          frame_done_q, frame_done_d;
    logic [7:0]    pad_cnt_q, pad_cnt_d;

    always_comb begin
        state_d      = state_q;
        ret_d        = ret_q;
        cnt_d        = cnt_q;
        sum_d        = sum_q;
        timer_d      = timer_q;
        tx_data_d    = tx_data_q;
        tx_wr_d      = 1'b0;
        frame_done_d = 1'b0;
        pad_cnt_d    = pad_cnt_q;
        fifo_rd      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (en && !fifo_empty) begin
                    tx_data_d = HDR;
                    cnt_d     = 8'd0;
                    sum_d     = 8'd0;
                    timer_d   = '0;
                    pad_cnt_d = 8'd0;
                    ret_d     = PAYLOAD;
                    state_d   = TX_ISSUE;
                end
            end
            TX_ISSUE: begin
                if (!tx_busy) begin
                    tx_wr_d = 1'b1;
                    state_d = TX_GUARD;
                end
            end
            TX_GUARD: state_d = TX_WAIT;
            TX_WAIT: begin
                if (!tx_busy) begin
                    state_d      = ret_q;
                    frame_done_d = (ret_q == DONE);
                end
            end
            PAYLOAD: begin
                if (cnt_q == LEN) begin
                    tx_data_d = sum_q;
                    ret_d     = DONE;
                    state_d   = TX_ISSUE;
                end else if (!fifo_empty) begin
                    // Pop is combinational so data lands exactly in FETCH.
                    fifo_rd = 1'b1;
                    timer_d = '0;
                    state_d = FETCH;
                end else if (timer_q == TLAST) begin
                    tx_data_d = PAD;
                    sum_d     = sum_q + PAD;
                    cnt_d     = cnt_q + 8'd1;
                    pad_cnt_d = pad_cnt_q + 8'd1;
                    timer_d   = '0;
                    ret_d     = PAYLOAD;
                    state_d   = TX_ISSUE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            FETCH: begin
                tx_data_d = fifo_dat;
                sum_d     = sum_q + fifo_dat;
                cnt_d     = cnt_q + 8'd1;
                ret_d     = PAYLOAD;
                state_d   = TX_ISSUE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        frame_busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            ret_q        <= IDLE;
            cnt_q        <= 8'd0;
            sum_q        <= 8'd0;
            timer_q      <= '0;
            tx_data_q    <= 8'h00;
            tx_wr_q      <= 1'b0;
            frame_busy_q <= 1'b0;
            frame_done_q <= 1'b0;
            pad_cnt_q    <= 8'd0;
        end else begin
            state_q      <= state_d;
            ret_q        <= ret_d;
            cnt_q        <= cnt_d;
            sum_q        <= sum_d;
            timer_q      <= timer_d;
            tx_data_q    <= tx_data_d;
            tx_wr_q      <= tx_wr_d;
            frame_busy_q <= frame_busy_d;
            frame_done_q <= frame_done_d;
            pad_cnt_q    <= pad_cnt_d;
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_wr      = tx_wr_q;
    assign frame_busy = frame_busy_q;
    assign frame_done = frame_done_q;
    assign pad_cnt    = pad_cnt_q;

endmodule

// File: tb/tb_fifo_uart_framer.sv
// Directed bench for fifo_uart_framer with a behavioural FIFO and UART.
// PKT_LEN=4, TIMEOUT=16.
module tb_fifo_uart_framer;

    localparam int PKT_LEN = 4;
    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       fifo_empty;
    logic       fifo_rd;
    logic [7:0] fifo_dat = 8'h00;
    logic [7:0] tx_data;
    logic       tx_wr;
    logic       tx_busy = 1'b0;
    logic       frame_busy;
    logic       frame_done;
    logic [7:0] pad_cnt;

    int vectors = 0;
    int errors  = 0;

    logic [7:0] fmem [128];
    logic [6:0] wp = 7'd0;
    logic [6:0] rp = 7'd0;

    logic [7:0] txlog [128];
    int         tlog  [128];
    int         tx_n = 0;
    int         cyc = 0;
    int         rd_n = 0;
    int         bad_rd = 0;
    int         done_n = 0;
    int         wr_busy = 0;
    int         unstable = 0;
    int         busy_left = 0;
    int         uart_hold = 2;
    logic [7:0] cur = 8'h00;

    fifo_uart_framer #(
        .PKT_LEN(PKT_LEN),
        .HDR    (8'hA0),
        .PAD    (8'h00),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .fifo_empty(fifo_empty),
        .fifo_rd   (fifo_rd),
        .fifo_dat  (fifo_dat),
        .tx_data   (tx_data),
        .tx_wr     (tx_wr),
        .tx_busy   (tx_busy),
        .frame_busy(frame_busy),
        .frame_done(frame_done),
        .pad_cnt   (pad_cnt)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (wp == rp);

    // FIFO read port, UART with programmable busy time, and event counters
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rd) begin
            if (fifo_empty) bad_rd <= bad_rd + 1;
            fifo_dat <= fmem[rp];
            rp <= rp + 7'd1;
            rd_n <= rd_n + 1;
        end
        if (frame_done) done_n <= done_n + 1;
        if (tx_wr) begin
            if (tx_busy) wr_busy <= wr_busy + 1;
            txlog[7'(tx_n)] <= tx_data;
            tlog[7'(tx_n)] <= cyc;
            tx_n <= tx_n + 1;
            cur <= tx_data;
            busy_left <= uart_hold;
            tx_busy <= (uart_hold != 0);
        end else if (busy_left > 1) begin
            busy_left <= busy_left - 1;
        end else begin
            busy_left <= 0;
            tx_busy <= 1'b0;
        end
        if (tx_busy && !tx_wr && tx_data !== cur) unstable <= unstable + 1;
    end

    task automatic push(input logic [7:0] b);
        fmem[wp] = b;
        wp = wp + 7'd1;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_frame(input int budget, output bit ok);
        int d0;
        d0 = done_n;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_n != d0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        en = 1'b0;
        cycles(3);
        vectors++;
        if (fifo_rd !== 1'b0) begin
            errors++;
            $display("FAIL reset fifo_rd: got %b want 0", fifo_rd);
        end
        vectors++;
        if (tx_wr !== 1'b0) begin
            errors++;
            $display("FAIL reset tx_wr: got %b want 0", tx_wr);
        end
        vectors++;
        if (tx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset tx_data: got %h want 00", tx_data);
        end
        vectors++;
        if (frame_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset frame_busy: got %b want 0", frame_busy);
        end
        vectors++;
        if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset frame_done: got %b want 0", frame_done);
        end
        vectors++;
        if (pad_cnt !== 8'h00) begin
            errors++;
            $display("FAIL reset pad_cnt: got %h want 00", pad_cnt);
        end
        reset = 1'b0;
        cycles(2);
    endtask

    task automatic test_basic;
        logic [7:0] exp [6] = '{8'hA0, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
        int n0, d0, c0;
        bit ok;
        uart_hold = 2;
        en = 1'b1;
        @(negedge clk);
        n0 = tx_n;
        d0 = done_n;
        c0 = cyc;
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        wait_frame(300, ok);
        vectors++;
        if (!ok) begin
            errors++;
            $display("FAIL basic timeout: frame_done never seen");
        end
        cycles(3);
        vectors++;
        if (tx_n - n0 != 6) begin
            errors++;
            $display("FAIL basic count: got %0d bytes want 6", tx_n - n0);
        end
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (txlog[7'(n0 + i)] !== exp[i]) begin
                errors++;
                $display("FAIL basic byte %0d: got %h want %h", i, txlog[7'(n0 + i)], exp[i]);
            end
        end
        vectors++;
        if (tlog[7'(n0)] - c0 != 2) begin
            errors++;
            $display("FAIL basic latency: got %0d want 2", tlog[7'(n0)] - c0);
        end
        vectors++;
        if (done_n - d0 != 1) begin
            errors++;
            $display("FAIL basic done pulses: got %0d want 1", done_n - d0);
        end
        vectors++;
        if (pad_cnt !== 8'h00) begin
            errors++;
            $display("FAIL basic pad_cnt: got %h want 00", pad_cnt);
        end
        vectors++;
        if (frame_busy !== 1'b0) begin
            errors++;
            $display("FAIL basic idle busy: got %b want 0", frame_busy);
        end
    endtask

    task automatic test_wrap;
        logic [7:0] exp [6] = '{8'hA0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFC};
        int n0, r0, b0;
        bit ok;
        n0 = tx_n;
        r0 = rd_n;
        b0 = bad_rd;
        push(8'hFF); push(8'hFF); push(8'hFF); push(8'hFF);
        wait_frame(300, ok);
        vectors++;
        if (!ok) begin
            errors++;
            $display("FAIL wrap timeout: frame_done never seen");
        end
        cycles(3);
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (txlog[7'(n0 + i)] !== exp[i]) begin
                errors++;
                $display("FAIL wrap byte %0d: got %h want %h", i, txlog[7'(n0 + i)], exp[i]);
            end
        end
        vectors++;
        if (rd_n - r0 != 4) begin
            errors++;
            $display("FAIL wrap pops: got %0d want 4", rd_n - r0);
        end
        vectors++;
        if (bad_rd != b0) begin
            errors++;
            $display("FAIL wrap pop-on-empty: got %0d want %0d", bad_rd, b0);
        end
    endtask

    task automatic test_timeout;
        logic [7:0] exp [6] = '{8'hA0, 8'h11, 8'h22, 8'h00, 8'h00, 8'h33};
        int n0;
        bit ok;
        n0 = tx_n;
        push(8'h11); push(8'h22);
        wait_frame(600, ok);
        vectors++;
        if (!ok) begin
            errors++;
            $display("FAIL timeout frame: frame_done never seen");
        end
        cycles(3);
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (txlog[7'(n0 + i)] !== exp[i]) begin
                errors++;
                $display("FAIL timeout byte %0d: got %h want %h", i, txlog[7'(n0 + i)], exp[i]);
            end
        end
        vectors++;
        if (pad_cnt !== 8'd2) begin
            errors++;
            $display("FAIL timeout pad_cnt: got %0d want 2", pad_cnt);
        end
        for (int i = 2; i < 4; i++) begin
            vectors++;
            if (tlog[7'(n0 + i + 1)] - tlog[7'(n0 + i)] < TIMEOUT) begin
                errors++;
                $display("FAIL timeout gap %0d: got %0d want >= %0d", i,
                         tlog[7'(n0 + i + 1)] - tlog[7'(n0 + i)], TIMEOUT);
            end
        end
    endtask

    task automatic test_busy;
        logic [7:0] exp [6] = '{8'hA0, 8'h05, 8'h06, 8'h07, 8'h08, 8'h1A};
        int n0, w0, u0;
        bit ok;
        n0 = tx_n;
        w0 = wr_busy;
        u0 = unstable;
        uart_hold = 50;
        push(8'h05); push(8'h06); push(8'h07); push(8'h08);
        wait_frame(2000, ok);
        vectors++;
        if (!ok) begin
            errors++;
            $display("FAIL busy timeout: frame_done never seen");
        end
        cycles(3);
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (txlog[7'(n0 + i)] !== exp[i]) begin
                errors++;
                $display("FAIL busy byte %0d: got %h want %h", i, txlog[7'(n0 + i)], exp[i]);
            end
        end
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (tlog[7'(n0 + i + 1)] - tlog[7'(n0 + i)] < 50) begin
                errors++;
                $display("FAIL busy spacing %0d: got %0d want >= 50", i,
                         tlog[7'(n0 + i + 1)] - tlog[7'(n0 + i)]);
            end
        end
        vectors++;
        if (wr_busy != w0) begin
            errors++;
            $display("FAIL busy tx_wr-while-busy: got %0d want %0d", wr_busy, w0);
        end
        vectors++;
        if (unstable != u0) begin
            errors++;
            $display("FAIL busy tx_data changes: got %0d want %0d", unstable, u0);
        end
        uart_hold = 2;
    endtask

    task automatic test_enable;
        logic [7:0] exp [6] = '{8'hA0, 8'h31, 8'h32, 8'h33, 8'h34, 8'hCA};
        int n0, r0;
        bit ok;
        bit seen;
        en = 1'b0;
        cycles(2);
        n0 = tx_n;
        r0 = rd_n;
        push(8'h31); push(8'h32); push(8'h33); push(8'h34);
        cycles(20);
        vectors++;
        if (tx_n != n0) begin
            errors++;
            $display("FAIL enable off tx: got %0d writes want 0", tx_n - n0);
        end
        vectors++;
        if (frame_busy !== 1'b0) begin
            errors++;
            $display("FAIL enable off busy: got %b want 0", frame_busy);
        end
        vectors++;
        if (rd_n != r0) begin
            errors++;
            $display("FAIL enable off pops: got %0d want 0", rd_n - r0);
        end
        en = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (frame_busy === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        vectors++;
        if (!seen) begin
            errors++;
            $display("FAIL enable start: frame_busy got 0 want 1");
        end
        cycles(3);
        en = 1'b0;
        wait_frame(300, ok);
        vectors++;
        if (!ok) begin
            errors++;
            $display("FAIL enable drop: frame_done never seen");
        end
        cycles(5);
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (txlog[7'(n0 + i)] !== exp[i]) begin
                errors++;
                $display("FAIL enable byte %0d: got %h want %h", i, txlog[7'(n0 + i)], exp[i]);
            end
        end
        n0 = tx_n;
        push(8'h41); push(8'h42); push(8'h43); push(8'h44);
        cycles(20);
        vectors++;
        if (tx_n != n0 || frame_busy !== 1'b0) begin
            errors++;
            $display("FAIL enable hold idle: got %0d writes busy=%b want 0/0",
                     tx_n - n0, frame_busy);
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] exp [6] = '{8'hA0, 8'h42, 8'h43, 8'h44, 8'h45, 8'h0E};
        int n0;
        bit ok;
        bit seen;
        n0 = tx_n;
        uart_hold = 30;
        en = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx_n - n0 >= 2) begin
                seen = 1'b1;
                break;
            end
        end
        vectors++;
        if (!seen) begin
            errors++;
            $display("FAIL midreset setup: got %0d writes want 2", tx_n - n0);
        end
        cycles(5);
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (tx_data !== 8'h00 || tx_wr !== 1'b0 || fifo_rd !== 1'b0) begin
            errors++;
            $display("FAIL midreset tx: got data=%h wr=%b rd=%b want 00/0/0",
                     tx_data, tx_wr, fifo_rd);
        end
        vectors++;
        if (frame_busy !== 1'b0 || frame_done !== 1'b0 || pad_cnt !== 8'h00) begin
            errors++;
            $display("FAIL midreset status: got busy=%b done=%b pad=%h want 0/0/00",
                     frame_busy, frame_done, pad_cnt);
        end
        push(8'h45);
        uart_hold = 2;
        reset = 1'b0;
        n0 = tx_n;
        wait_frame(400, ok);
        vectors++;
        if (!ok) begin
            errors++;
            $display("FAIL midreset restart: frame_done never seen");
        end
        cycles(3);
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (txlog[7'(n0 + i)] !== exp[i]) begin
                errors++;
                $display("FAIL midreset byte %0d: got %h want %h", i, txlog[7'(n0 + i)], exp[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_timeout();
        test_busy();
        test_enable();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", errors);
        $fatal(1);
    end

endmodule
